life_run_controller: RTL and testbench
======================================

Name: life_run_controller

Overview:
Sequencer for the 16x16 Game of Life datapath. Owns the current board register and the generation counter. Issues one-generation step requests to the algorithm datapath using a req/ack handshake, at a programmable tick rate or as single steps. Decodes run/step/clear buttons into a SET/RUN/STOP mode machine and sits between the board editor, the algorithm block and the display path.

Parameters:
TICK_PERIOD, 50_000_000, clk cycles between automatic step requests in RUN (min 1)
TICK_W, 26, width of internal tick counter (must hold TICK_PERIOD-1)
CNT_W, 16, generation counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_run  in  1  level, externally debounced; rising edge toggles run/stop
btn_step  in  1  level; rising edge requests one generation in STOP
btn_clear  in  1  level; rising edge returns to SET and clears state
setup_board  in  256  board from editor, bit 16*r+c
next_board  in  256  algorithm result, valid when step_ack=1
step_ack  in  1  one-cycle pulse: next_board valid, request consumed
step_req  out  1  step request to algorithm, level, held until ack
board_o  out  256  current board
generation_cnt_o  out  CNT_W  accepted generations since last SET
mode_o  out  3  one-hot: SET=001, RUN=010, STOP=100
halted_o  out  1  auto-halt flag (see Optional Feature)

Behaviour:
- Reset: mode_o=001, board_o=0, generation_cnt_o=0, step_req=0, halted_o=0, tick counter=0. Button history registers reset to 1, so a button held through reset produces no edge.
- Edge detect: a button press is registered when the input is 1 and its history register is 0. One press per rising edge. Holding a button produces no repeat.
- Internal states: SET, RUN_WAIT, RUN_BUSY, STOP, STEP_BUSY.
- mode_o decoding: RUN_* gives 010. STOP and STEP_BUSY give 100.
- SET: board_o <= setup_board every cycle.
  - run press: board_o <= setup_board, tick counter=0, go to RUN_WAIT.
  - step press: ignored.
- RUN_WAIT: tick counter increments each cycle. At TICK_PERIOD-1 it wraps to 0, step_req asserts next cycle, go to RUN_BUSY.
  - run press: go to STOP.
- RUN_BUSY: tick counter keeps counting. Ticks arriving while busy are dropped (no queuing).
  - On step_ack: board_o <= next_board, generation_cnt_o +1, step_req=0 from the next cycle, go to RUN_WAIT.
  - run press while busy: latch pause_pending. The in-flight step completes, then go to STOP.
- STOP: holds board_o.
  - step press: step_req=1 next cycle, go to STEP_BUSY.
  - run press: tick counter=0, go to RUN_WAIT.
- STEP_BUSY: on ack, update as in RUN_BUSY, then return to STOP. Run and step presses are ignored.
- step_req handshake: never deasserts before ack. Deasserts the cycle after ack. At most one outstanding request.
- step_ack received while no request is outstanding is ignored.
- Generation counter saturates at all-ones and never wraps.
- btn_clear press, any state (highest priority, including same cycle as step_ack or other presses):
  - go to SET; board_o <= setup_board; generation_cnt_o=0; step_req=0 next cycle; halted_o=0; pause_pending=0.
  - The aborted request's late ack is ignored.
- Reset mid-handshake behaves as clear plus full register reset. The algorithm block shares the reset.

Optional Feature:
Macro LIFE_STABLE_HALT_EN.
- Defined: on an accepted ack in RUN_BUSY where next_board == board_o (still life) or next_board == 0 (extinct), perform the normal update and counter increment, then go to STOP with halted_o=1. halted_o clears on the next run press or clear.
- Undefined: no comparators are built, halted_o is tied 0, and RUN continues indefinitely.

Decomposition:
- Package life_pkg: BOARD_CELLS=256, BOARD_DIM=16, one-hot mode constants MODE_SET/MODE_RUN/MODE_STOP, internal state enum.
- Sub-module life_tick_gen: free-running divider with sync clear and enable, 1-cycle tick output, parameterised by TICK_PERIOD/TICK_W.
- Edge detection stays inline.

Test Plan:
- Reset held 3 cycles with btn_run=1 -> mode_o=001, board_o=0, gen=0, step_req=0. Releasing and re-pressing gives exactly one transition to 010.
- TICK_PERIOD=4, setup_board=blinker (cells 0x11,0x12,0x13), run press -> step_req rises 5 cycles after the press. Ack after 2 cycles with vertical blinker -> board_o updates next cycle, gen=1, step_req low the cycle after ack.
- Run press during RUN_BUSY -> ack 3 cycles later still accepted, gen=1, mode_o=100. No step_req over the next 20 cycles.
- STOP, btn_step held 10 cycles -> exactly one request and gen +1, mode_o stays 100. Run press resumes with first req TICK_PERIOD cycles later.
- btn_clear in same cycle as step_ack -> mode_o=001, gen=0, board_o=setup_board, next_board discarded. A spurious ack 2 cycles later is ignored.
- LIFE_STABLE_HALT_EN with 2x2 block, ack returns identical board -> gen=1, halted_o=1, mode_o=100. Without the macro, mode_o stays 010 and gen keeps incrementing.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants, state encoding and mode decode for the Life run controller.
package life_pkg;

   localparam int unsigned BOARD_DIM   = 16;
   localparam int unsigned BOARD_CELLS = BOARD_DIM * BOARD_DIM;
   localparam int unsigned MODE_W      = 3;

   localparam logic [MODE_W-1:0] MODE_SET  = 3'b001;
   localparam logic [MODE_W-1:0] MODE_RUN  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_STOP = 3'b100;

   typedef logic [BOARD_CELLS-1:0] board_t;

   typedef enum logic [2:0] {
      ST_SET,
      ST_RUN_WAIT,
      ST_RUN_BUSY,
      ST_STOP,
      ST_STEP_BUSY
   } state_t;

   // Collapse the internal states onto the user-visible one-hot mode.
   function automatic logic [MODE_W-1:0] mode_of(input state_t s);
      logic [MODE_W-1:0] m;
      case (s)
         ST_RUN_WAIT, ST_RUN_BUSY: m = MODE_RUN;
         ST_STOP, ST_STEP_BUSY:    m = MODE_STOP;
         default:                  m = MODE_SET;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/life_tick_gen.sv
// Free-running tick divider: one-cycle tick every TICK_PERIOD enabled cycles.
module life_tick_gen #(
   parameter int unsigned TICK_PERIOD = 50_000_000,
   parameter int unsigned TICK_W      = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick_c
);

   localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_PERIOD - 1);

   logic [TICK_W-1:0] cnt_q;

   // Tick fires on the wrap cycle; a clear suppresses it.
   assign tick_c = enable && !clear && (cnt_q == LAST);

   // Divider counter with synchronous clear and wrap at TICK_PERIOD-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + TICK_W'(1);
      end
   end

endmodule

// File: rtl/life_run_controller.sv
// Game of Life run sequencer: owns the board and generation counter, decodes
// run/step/clear buttons and issues req/ack step requests to the datapath.
// Optional auto-halt on still life / extinction: define LIFE_STABLE_HALT_EN.
module life_run_controller
   import life_pkg::*;
#(
   parameter int unsigned TICK_PERIOD = 50_000_000,
   parameter int unsigned TICK_W      = 26,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_run,
   input  logic                   btn_step,
   input  logic                   btn_clear,
   input  logic [BOARD_CELLS-1:0] setup_board,
   input  logic [BOARD_CELLS-1:0] next_board,
   input  logic                   step_ack,
   output logic                   step_req,
   output logic [BOARD_CELLS-1:0] board_o,
   output logic [CNT_W-1:0]       generation_cnt_o,
   output logic [MODE_W-1:0]      mode_o,
   output logic                   halted_o
);

   state_t            state_q, state_n;
   board_t            board_q, board_n;
   logic [CNT_W-1:0]  gen_q, gen_n, gen_inc;
   logic              req_q, req_n;
   logic              pause_q, pause_n;
   logic [MODE_W-1:0] mode_q;
   logic              run_hist_q, step_hist_q, clear_hist_q;
   logic              run_press, step_press, clear_press;
   logic              ack_ok, run_active, tick_c;
`ifdef LIFE_STABLE_HALT_EN
   logic              halted_q, halted_n;
   logic              stable;
`endif

   // Rising-edge detect against history registers that reset high.
   assign run_press   = btn_run   & ~run_hist_q;
   assign step_press  = btn_step  & ~step_hist_q;
   assign clear_press = btn_clear & ~clear_hist_q;

   // Acks only count while a request is actually outstanding.
   assign ack_ok     = step_ack & req_q;
   assign run_active = (state_q == ST_RUN_WAIT) || (state_q == ST_RUN_BUSY);
   assign gen_inc    = (gen_q == '1) ? gen_q : gen_q + CNT_W'(1);

`ifdef LIFE_STABLE_HALT_EN
   assign stable = (next_board == board_q) || (next_board == '0);
`endif

   // Counter only runs in RUN; anywhere else it is held at zero.
   life_tick_gen #(
      .TICK_PERIOD (TICK_PERIOD),
      .TICK_W      (TICK_W)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear_press | ~run_active),
      .enable (run_active),
      .tick_c (tick_c)
   );

   // Next-state and datapath update; clear overrides everything.
   always_comb begin
      state_n = state_q;
      board_n = board_q;
      gen_n   = gen_q;
      req_n   = req_q;
      pause_n = pause_q;
`ifdef LIFE_STABLE_HALT_EN
      halted_n = halted_q;
`endif
      if (clear_press) begin
         state_n = ST_SET;
         board_n = setup_board;
         gen_n   = '0;
         req_n   = 1'b0;
         pause_n = 1'b0;
`ifdef LIFE_STABLE_HALT_EN
         halted_n = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_SET: begin
               board_n = setup_board;
               if (run_press) begin
                  state_n = ST_RUN_WAIT;
`ifdef LIFE_STABLE_HALT_EN
                  halted_n = 1'b0;
`endif
               end
            end
            ST_RUN_WAIT: begin
               if (run_press) begin
                  state_n = ST_STOP;
               end else if (tick_c) begin
                  state_n = ST_RUN_BUSY;
                  req_n   = 1'b1;
               end
            end
            ST_RUN_BUSY: begin
               if (ack_ok) begin
                  board_n = next_board;
                  gen_n   = gen_inc;
                  req_n   = 1'b0;
                  pause_n = 1'b0;
                  state_n = (pause_q || run_press) ? ST_STOP : ST_RUN_WAIT;
`ifdef LIFE_STABLE_HALT_EN
                  if (stable) begin
                     state_n  = ST_STOP;
                     halted_n = 1'b1;
                  end
`endif
               end else if (run_press) begin
                  pause_n = 1'b1;
               end
            end
            ST_STOP: begin
               if (step_press) begin
                  state_n = ST_STEP_BUSY;
                  req_n   = 1'b1;
               end else if (run_press) begin
                  state_n = ST_RUN_WAIT;
`ifdef LIFE_STABLE_HALT_EN
                  halted_n = 1'b0;
`endif
               end
            end
            ST_STEP_BUSY: begin
               if (ack_ok) begin
                  board_n = next_board;
                  gen_n   = gen_inc;
                  req_n   = 1'b0;
                  state_n = ST_STOP;
               end
            end
            default: begin
               state_n = ST_SET;
               req_n   = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and button history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_SET;
         board_q      <= '0;
         gen_q        <= '0;
         req_q        <= 1'b0;
         pause_q      <= 1'b0;
         mode_q       <= MODE_SET;
         run_hist_q   <= 1'b1;
         step_hist_q  <= 1'b1;
         clear_hist_q <= 1'b1;
      end else begin
         state_q      <= state_n;
         board_q      <= board_n;
         gen_q        <= gen_n;
         req_q        <= req_n;
         pause_q      <= pause_n;
         mode_q       <= mode_of(state_n);
         run_hist_q   <= btn_run;
         step_hist_q  <= btn_step;
         clear_hist_q <= btn_clear;
      end
   end

`ifdef LIFE_STABLE_HALT_EN
   // Auto-halt flag register.
   always_ff @(posedge clk) begin
      if (reset) halted_q <= 1'b0;
      else       halted_q <= halted_n;
   end
   assign halted_o = halted_q;
`else
   assign halted_o = 1'b0;
`endif

   assign step_req         = req_q;
   assign board_o          = board_q;
   assign generation_cnt_o = gen_q;
   assign mode_o           = mode_q;

endmodule

// File: tb/tb_life_run_controller.sv
// Self-checking bench for life_run_controller. The bench plays the algorithm
// block, computing each next generation with its own Life rule function.
module tb_life_run_controller;

   localparam int unsigned TP      = 4;
   localparam int unsigned TW      = 3;
   localparam int unsigned CW      = 4;
   localparam int          GEN_MAX = 15;
   localparam logic [2:0]  M_SET   = 3'b001;
   localparam logic [2:0]  M_RUN   = 3'b010;
   localparam logic [2:0]  M_STOP  = 3'b100;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           btn_run = 1'b0, btn_step = 1'b0, btn_clear = 1'b0;
   logic [255:0]   setup_board = '0, next_board = '0;
   logic           step_ack = 1'b0;
   logic           step_req;
   logic [255:0]   board_o;
   logic [CW-1:0]  generation_cnt_o;
   logic [2:0]     mode_o;
   logic           halted_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;
   int run_edge = 0;
   logic [255:0] exp_board;
   int exp_gen;

   life_run_controller #(.TICK_PERIOD(TP), .TICK_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
      .btn_clear(btn_clear), .setup_board(setup_board), .next_board(next_board),
      .step_ack(step_ack), .step_req(step_req), .board_o(board_o),
      .generation_cnt_o(generation_cnt_o), .mode_o(mode_o), .halted_o(halted_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   // Reference Life rule, dead cells beyond the edges.
   function automatic logic [255:0] life_step(input logic [255:0] b);
      logic [255:0] n;
      int cnt;
      n = '0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
                     cnt += int'(b[16*(r+dr) + (c+dc)]);
            n[16*r+c] = (cnt == 3) || (cnt == 2 && b[16*r+c] == 1'b1);
         end
      return n;
   endfunction

   function automatic logic [255:0] rand_board();
      logic [255:0] b;
      for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom();
      return b;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic press_clear();
      btn_clear = 1'b1; cyc(1); btn_clear = 1'b0;
      exp_board = setup_board; exp_gen = 0;
   endtask

   task automatic press_run();
      btn_run = 1'b1; cyc(1); btn_run = 1'b0;
      run_edge = cyc_cnt;
   endtask

   task automatic pulse_ack(input logic [255:0] nb);
      step_ack = 1'b1; next_board = nb; cyc(1);
      step_ack = 1'b0; next_board = rand_board();
   endtask

   // Wait for step_req; k = cycles waited, 0 on timeout. Optionally sprays stray acks.
   task automatic wait_req(input int bound, input bit spurious, output int k);
      k = 0;
      for (int i = 1; i <= bound; i++) begin
         if (spurious && step_req === 1'b0 && $urandom_range(0, 3) == 0) begin
            step_ack = 1'b1; next_board = rand_board();
         end
         cyc(1);
         step_ack = 1'b0;
         if (step_req === 1'b1) begin k = i; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; btn_run = 1'b1; setup_board = rand_board();
      cyc(3);
      n_checks++; if (mode_o !== M_SET) begin n_fail++; $display("FAIL reset_mode: got %b want %b", mode_o, M_SET); end
      n_checks++; if (board_o !== '0) begin n_fail++; $display("FAIL reset_board: got %h want 0", board_o); end
      n_checks++; if (generation_cnt_o !== '0) begin n_fail++; $display("FAIL reset_gen: got %0d want 0", generation_cnt_o); end
      n_checks++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", step_req); end
      n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted_o); end
      reset = 1'b0;
      cyc(3);
      n_checks++; if (mode_o !== M_SET) begin n_fail++; $display("FAIL held_run_no_edge: got %b want %b", mode_o, M_SET); end
      n_checks++; if (board_o !== setup_board) begin n_fail++; $display("FAIL set_tracks_setup: got %h want %h", board_o, setup_board); end
      btn_run = 1'b0; cyc(1);
      btn_run = 1'b1; cyc(1);
      n_checks++; if (mode_o !== M_RUN) begin n_fail++; $display("FAIL run_after_press: got %b want %b", mode_o, M_RUN); end
      cyc(5);
      n_checks++; if (mode_o !== M_RUN) begin n_fail++; $display("FAIL hold_no_repeat: got %b want %b", mode_o, M_RUN); end
      btn_run = 1'b0;
      press_clear();
      n_checks++; if (mode_o !== M_SET || step_req !== 1'b0) begin n_fail++; $display("FAIL clear_from_run: mode %b req %b want %b 0", mode_o, step_req, M_SET); end
   endtask

   task automatic test_blinker();
      logic [255:0] horiz, vert;
      int k;
      horiz = '0; horiz[17] = 1'b1; horiz[18] = 1'b1; horiz[19] = 1'b1;
      vert  = '0; vert[2]   = 1'b1; vert[18]  = 1'b1; vert[34]  = 1'b1;
      setup_board = horiz;
      press_clear();
      press_run();
      wait_req(20, 1'b0, k);
      // +1 counts the cycle the button was raised.
      n_checks++; if (k + 1 != int'(TP) + 1) begin n_fail++; $display("FAIL first_req_latency: got %0d want %0d", k + 1, TP + 1); end
      n_checks++; if (board_o !== horiz) begin n_fail++; $display("FAIL board_before_ack: got %h want %h", board_o, horiz); end
      cyc(1);
      n_checks++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL req_held_1: got %b want 1", step_req); end
      cyc(1);
      n_checks++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL req_held_2: got %b want 1", step_req); end
      pulse_ack(vert);
      exp_board = vert; exp_gen = 1;
      n_checks++; if (board_o !== vert) begin n_fail++; $display("FAIL blinker_board: got %h want %h", board_o, vert); end
      n_checks++; if (generation_cnt_o !== CW'(exp_gen)) begin n_fail++; $display("FAIL blinker_gen: got %0d want %0d", generation_cnt_o, exp_gen); end
      n_checks++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL req_drop_after_ack: got %b want 0", step_req); end
      n_checks++; if (mode_o !== M_RUN) begin n_fail++; $display("FAIL blinker_mode: got %b want %b", mode_o, M_RUN); end
   endtask

   task automatic test_pause_busy();
      int k, stray;
      logic [255:0] nb;
      setup_board = rand_board();
      press_clear();
      press_run();
      wait_req(20, 1'b0, k);
      n_checks++; if (k != int'(TP)) begin n_fail++; $display("FAIL pause_req_wait: got %0d want %0d", k, TP); end
      press_run();
      n_checks++; if (step_req !== 1'b1 || mode_o !== M_RUN) begin n_fail++; $display("FAIL pause_in_busy: req %b mode %b want 1 %b", step_req, mode_o, M_RUN); end
      cyc(1);
      nb = life_step(exp_board);
      pulse_ack(nb);
      exp_board = nb; exp_gen = 1;
      n_checks++; if (generation_cnt_o !== CW'(exp_gen) || board_o !== exp_board) begin n_fail++; $display("FAIL pause_ack_accepted: gen %0d want %0d", generation_cnt_o, exp_gen); end
      n_checks++; if (mode_o !== M_STOP) begin n_fail++; $display("FAIL pause_to_stop: got %b want %b", mode_o, M_STOP); end
      stray = 0;
      for (int i = 0; i < 20; i++) begin cyc(1); if (step_req !== 1'b0) stray++; end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL stop_no_req: got %0d req cycles want 0", stray); end
   endtask

   task automatic test_step_hold();
      int d, rises, k;
      logic prev;
      d = int'($urandom_range(1, 4)); rises = 0; prev = 1'b0;
      btn_step = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == d) begin step_ack = 1'b1; next_board = life_step(exp_board); end
         cyc(1);
         if (i == d) begin step_ack = 1'b0; exp_board = life_step(exp_board); exp_gen++; end
         if (step_req === 1'b1 && prev === 1'b0) rises++;
         prev = step_req;
      end
      btn_step = 1'b0;
      n_checks++; if (rises != 1) begin n_fail++; $display("FAIL step_single_req: got %0d want 1", rises); end
      n_checks++; if (generation_cnt_o !== CW'(exp_gen) || board_o !== exp_board) begin n_fail++; $display("FAIL step_gen: got %0d want %0d", generation_cnt_o, exp_gen); end
      n_checks++; if (mode_o !== M_STOP || step_req !== 1'b0) begin n_fail++; $display("FAIL step_stays_stop: mode %b req %b want %b 0", mode_o, step_req, M_STOP); end
      press_run();
      wait_req(20, 1'b0, k);
      n_checks++; if (k != int'(TP)) begin n_fail++; $display("FAIL resume_latency: got %0d want %0d", k, TP); end
      n_checks++; if (mode_o !== M_RUN) begin n_fail++; $display("FAIL resume_mode: got %b want %b", mode_o, M_RUN); end
   endtask

   task automatic test_clear_ack();
      setup_board = rand_board();
      btn_clear = 1'b1; step_ack = 1'b1; next_board = rand_board();
      cyc(1);
      btn_clear = 1'b0; step_ack = 1'b0;
      exp_board = setup_board; exp_gen = 0;
      n_checks++; if (mode_o !== M_SET) begin n_fail++; $display("FAIL clear_ack_mode: got %b want %b", mode_o, M_SET); end
      n_checks++; if (generation_cnt_o !== '0) begin n_fail++; $display("FAIL clear_ack_gen: got %0d want 0", generation_cnt_o); end
      n_checks++; if (board_o !== setup_board) begin n_fail++; $display("FAIL clear_ack_board: got %h want %h", board_o, setup_board); end
      n_checks++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL clear_ack_req: got %b want 0", step_req); end
      cyc(1);
      pulse_ack(rand_board());
      n_checks++; if (generation_cnt_o !== '0 || mode_o !== M_SET || step_req !== 1'b0) begin n_fail++; $display("FAIL late_ack_ignored: gen %0d mode %b req %b", generation_cnt_o, mode_o, step_req); end
   endtask

   task automatic test_spurious_stop();
      setup_board = rand_board();
      btn_step = 1'b1; cyc(1); btn_step = 1'b0;
      n_checks++; if (step_req !== 1'b0 || mode_o !== M_SET) begin n_fail++; $display("FAIL step_in_set: req %b mode %b want 0 %b", step_req, mode_o, M_SET); end
      press_run();
      exp_board = setup_board;
      cyc(1);
      press_run();
      setup_board = rand_board();
      pulse_ack(rand_board());
      n_checks++; if (mode_o !== M_STOP) begin n_fail++; $display("FAIL wait_to_stop: got %b want %b", mode_o, M_STOP); end
      n_checks++; if (board_o !== exp_board || generation_cnt_o !== '0) begin n_fail++; $display("FAIL stray_ack_stop: gen %0d board %h want 0 %h", generation_cnt_o, board_o, exp_board); end
      press_clear();
   endtask

   task automatic test_stable_block();
      logic [255:0] blk;
      int k, stray;
      blk = '0; blk[85] = 1'b1; blk[86] = 1'b1; blk[101] = 1'b1; blk[102] = 1'b1;
      setup_board = blk;
      press_clear();
      press_run();
      wait_req(20, 1'b0, k);
      n_checks++; if (k == 0) begin n_fail++; $display("FAIL block_req_timeout: got %0d want %0d", k, TP); end
      pulse_ack(life_step(blk));
      exp_gen = 1;
      n_checks++; if (generation_cnt_o !== CW'(1) || board_o !== blk) begin n_fail++; $display("FAIL block_gen: got %0d want 1", generation_cnt_o); end
`ifdef LIFE_STABLE_HALT_EN
      n_checks++; if (mode_o !== M_STOP || halted_o !== 1'b1) begin n_fail++; $display("FAIL block_halt: mode %b halted %b want %b 1", mode_o, halted_o, M_STOP); end
      stray = 0;
      for (int i = 0; i < 10; i++) begin cyc(1); if (step_req !== 1'b0) stray++; end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL halted_no_req: got %0d want 0", stray); end
      press_run();
      n_checks++; if (halted_o !== 1'b0 || mode_o !== M_RUN) begin n_fail++; $display("FAIL halt_release: halted %b mode %b want 0 %b", halted_o, mode_o, M_RUN); end
`else
      n_checks++; if (mode_o !== M_RUN || halted_o !== 1'b0) begin n_fail++; $display("FAIL block_keeps_run: mode %b halted %b want %b 0", mode_o, halted_o, M_RUN); end
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         wait_req(20, 1'b0, k);
         if (k == 0) stray++;
         pulse_ack(blk);
         exp_gen++;
      end
      n_checks++; if (stray != 0 || generation_cnt_o !== CW'(exp_gen) || mode_o !== M_RUN) begin n_fail++; $display("FAIL block_run_on: gen %0d want %0d timeouts %0d", generation_cnt_o, exp_gen, stray); end
`endif
      press_clear();
   endtask

   task automatic test_random_run();
      int k, d, last_edge, want_edge;
      logic [255:0] nb;
      bit halt_exp;
      setup_board = rand_board();
      press_clear();
      press_run();
      last_edge = run_edge;
      for (int n = 0; n < 20; n++) begin
         wait_req(3 * int'(TP) + 4, 1'b1, k);
         n_checks++; if (k == 0) begin n_fail++; $display("FAIL rand_req_timeout: iter %0d got none want req", n); break; end
         // Ticks land every TP cycles after the run press; ones during a busy step are lost.
         want_edge = run_edge + int'(TP) * ((last_edge - run_edge) / int'(TP) + 1);
         n_checks++; if (cyc_cnt != want_edge) begin n_fail++; $display("FAIL rand_tick_phase: iter %0d got cycle %0d want %0d", n, cyc_cnt, want_edge); end
         d = int'($urandom_range(0, 3));
         cyc(d);
         nb = life_step(exp_board);
         halt_exp = (nb == exp_board) || (nb == '0);
         pulse_ack(nb);
         last_edge = cyc_cnt;
         exp_board = nb;
         exp_gen = (exp_gen + 1 > GEN_MAX) ? GEN_MAX : exp_gen + 1;
         n_checks++; if (board_o !== exp_board || generation_cnt_o !== CW'(exp_gen)) begin n_fail++; $display("FAIL rand_update: iter %0d gen %0d want %0d", n, generation_cnt_o, exp_gen); end
`ifdef LIFE_STABLE_HALT_EN
         if (halt_exp) begin
            n_checks++; if (mode_o !== M_STOP || halted_o !== 1'b1) begin n_fail++; $display("FAIL rand_halt: mode %b halted %b", mode_o, halted_o); end
            break;
         end
`endif
         n_checks++; if (mode_o !== M_RUN || step_req !== 1'b0) begin n_fail++; $display("FAIL rand_mode: iter %0d mode %b req %b want %b 0 halt %0d", n, mode_o, step_req, M_RUN, halt_exp); end
      end
      press_clear();
   endtask

   initial begin
      exp_board = '0; exp_gen = 0;
      test_reset();
      test_blinker();
      test_pause_busy();
      test_step_hold();
      test_clear_ack();
      test_spurious_stop();
      test_stable_block();
      test_random_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
